// File: rtl/lag_data_ch_capture_ctrl.sv
// lag_data_ch_capture_ctrl
//   Takes a single-channel snapshot from the per-channel lag-check stream and
//   presents it as a 32-bit word for the lag-data software register. Software
//   arms a capture through cfg_word. The block waits for the target channel,
//   latches data, status and a sequence count, then holds the word until the
//   arm bit drops. In auto-scan mode the target steps through 0..N_CH-1 on
//   successive arms.
//
// Ports
//   user_clk      : single clock
//   user_rst_n    : asynchronous active-low reset
//   stream_valid  : stream beat qualifier (no backpressure)
//   stream_ch     : channel index of the current beat
//   stream_data   : lag-check data of the current beat
//   cfg_word      : [0] arm, [1] auto_scan, [15:8] manual target channel
//   user_data_out : [31] valid, [30] timeout, [29:24] seq, [23:16] channel,
//                   [15:0] data
//   busy          : high while waiting for the target channel
//
// Parameters
//   N_CH        : channel count (2..256); auto-scan wraps at N_CH-1
//   TIMEOUT_CYC : WAIT cycles without a match before giving up (2..65535)
module lag_data_ch_capture_ctrl #(
  parameter int N_CH        = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        stream_valid,
  input  logic [7:0]  stream_ch,
  input  logic [15:0] stream_data,
  input  logic [31:0] cfg_word,
  output logic [31:0] user_data_out,
  output logic        busy
);

  localparam logic [7:0]  SCAN_LAST = 8'(N_CH - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] cfg_q;
  logic        arm_prev_q;
  logic [7:0]  target_q, target_d;
  logic        auto_q, auto_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  scan_ptr_q, scan_ptr_d;
  logic [31:0] out_q, out_d;

  logic arm_rise, arm_drop, hit, tmo;

  // Only arm, auto_scan and the target field carry meaning.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_q[31:16], cfg_q[7:2]};

  assign arm_rise = cfg_q[0] & ~arm_prev_q;
  assign arm_drop = ~cfg_q[0];
  assign hit      = stream_valid && (stream_ch == target_q);
  assign tmo      = (cnt_q == TMO_LAST);

  // config sampling + state register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cfg_q      <= '0;
      arm_prev_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      cfg_q      <= cfg_word;
      arm_prev_q <= cfg_q[0];
      state_q    <= state_d;
    end
  end

  // next-state logic; an arm drop during WAIT aborts even if a beat matches
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arm_rise) state_d = S_WAIT;
      S_WAIT: begin
        if (arm_drop)        state_d = S_IDLE;
        else if (hit || tmo) state_d = S_HOLD;
      end
      S_HOLD: if (arm_drop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output / datapath next-state logic
  always_comb begin
    target_d   = target_q;
    auto_d     = auto_q;
    cnt_d      = cnt_q;
    scan_ptr_d = scan_ptr_q;
    out_d      = out_q;
    case (state_q)
      S_IDLE: begin
        if (arm_rise) begin
          auto_d      = cfg_q[1];
          target_d    = cfg_q[1] ? scan_ptr_q : cfg_q[15:8];
          cnt_d       = '0;
          out_d[31:30] = 2'b00;
        end
      end
      S_WAIT: begin
        if (!arm_drop) begin
          if (hit || tmo) begin
            // a match in the final WAIT cycle wins over the timeout
            out_d[31]    = 1'b1;
            out_d[30]    = ~hit;
            out_d[29:24] = out_q[29:24] + 6'd1;
            out_d[23:16] = target_q;
            if (hit) out_d[15:0] = stream_data;
            if (auto_q)
              scan_ptr_d = (scan_ptr_q == SCAN_LAST) ? 8'd0 : scan_ptr_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      target_q   <= '0;
      auto_q     <= 1'b0;
      cnt_q      <= '0;
      scan_ptr_q <= '0;
      out_q      <= '0;
    end else begin
      target_q   <= target_d;
      auto_q     <= auto_d;
      cnt_q      <= cnt_d;
      scan_ptr_q <= scan_ptr_d;
      out_q      <= out_d;
    end
  end

  assign user_data_out = out_q;
  assign busy          = (state_q == S_WAIT);

endmodule
